// File: rtl/time_adj_pkg.sv
// Shared constants and types for the time field adjuster:
// PS/2 prefix bytes, default key scancodes and the RUN/EDIT mode encoding.
package time_adj_pkg;

  // PS/2 set-2 prefix bytes
  localparam logic [7:0] SC_BRK = 8'hF0;  // break (key release) prefix
  localparam logic [7:0] SC_EXT = 8'hE0;  // extended-key prefix

  // Default navigation/edit scancodes
  localparam logic [7:0] K_UP_DEF = 8'h75;
  localparam logic [7:0] K_DN_DEF = 8'h72;
  localparam logic [7:0] K_LT_DEF = 8'h6B;
  localparam logic [7:0] K_RT_DEF = 8'h74;
  localparam logic [7:0] K_EN_DEF = 8'h5A;

  // Operating mode; the encoding doubles as the editing flag
  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_EDIT = 1'b1
  } mode_t;

endpackage

// File: rtl/ps2_key_filter.sv
// Strips PS/2 break and extended prefixes from the raw byte stream and
// emits a one-cycle key_valid strobe for each key press (make code).
module ps2_key_filter
  import time_adj_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       got_data,
  output logic       key_valid,
  output logic [7:0] key_code
);

  logic       brk_r;
  logic       key_valid_r;
  logic [7:0] key_code_r;

  // Track the break prefix and emit press events one cycle after the byte strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      brk_r       <= 1'b0;
      key_valid_r <= 1'b0;
      key_code_r  <= 8'h00;
    end else begin
      key_valid_r <= 1'b0;
      if (got_data) begin
        case (scan_code)
          SC_BRK: begin
            brk_r <= 1'b1;
          end
          SC_EXT: begin
            // Extended prefix carries no key information; break state is kept
            brk_r <= brk_r;
          end
          default: begin
            if (brk_r) begin
              // Byte following F0 is a release: swallow it
              brk_r <= 1'b0;
            end else begin
              key_valid_r <= 1'b1;
              key_code_r  <= scan_code;
            end
          end
        endcase
      end else begin
        brk_r <= brk_r;
      end
    end
  end

  assign key_valid = key_valid_r;
  assign key_code  = key_code_r;

endmodule

// File: rtl/time_field_adjuster.sv
// Bank of NCH wrap-around counters (seconds/minutes/hours by default).
// RUN mode advances the fields from a tick with carry ripple; EDIT mode lets
// keyboard keys move a cursor and step the selected field without carry.
module time_field_adjuster
  import time_adj_pkg::*;
#(
  parameter int              NCH  = 3,
  parameter int              W    = 6,
  parameter int              CW   = 2,
  parameter logic [NCH*W-1:0] MAXV = {6'd23, 6'd59, 6'd59},
  parameter logic [7:0]      K_UP = K_UP_DEF,
  parameter logic [7:0]      K_DN = K_DN_DEF,
  parameter logic [7:0]      K_LT = K_LT_DEF,
  parameter logic [7:0]      K_RT = K_RT_DEF,
  parameter logic [7:0]      K_EN = K_EN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       scan_code,
  input  logic             got_data,
  input  logic             tick,
  output logic [NCH*W-1:0] cuenta,
  output logic [CW-1:0]    cursor,
  output logic             editing,
  output logic             rollover
);

  localparam logic [CW-1:0] CUR_LAST = CW'(NCH - 1);
  localparam logic [CW-1:0] CUR_ZERO = {CW{1'b0}};

  logic          key_valid_s;
  logic [7:0]    key_code_s;
  mode_t         mode_r;
  logic [CW-1:0] cursor_r;
  logic          rollover_r;
  logic [NCH:0]  carry_s;
  logic [NCH-1:0] wrap_s;

  logic key_en_s;
  logic key_up_s;
  logic key_dn_s;
  logic key_lt_s;
  logic key_rt_s;
  logic in_edit_s;

  ps2_key_filter u_key_filter (
    .clk       (clk),
    .rst       (rst),
    .scan_code (scan_code),
    .got_data  (got_data),
    .key_valid (key_valid_s),
    .key_code  (key_code_s)
  );

  // Decode the filtered key into one-hot action strobes
  always_comb begin
    key_en_s  = 1'b0;
    key_up_s  = 1'b0;
    key_dn_s  = 1'b0;
    key_lt_s  = 1'b0;
    key_rt_s  = 1'b0;
    in_edit_s = (mode_r == MODE_EDIT);
    if (key_valid_s) begin
      key_en_s = (key_code_s == K_EN);
      key_up_s = (key_code_s == K_UP);
      key_dn_s = (key_code_s == K_DN);
      key_lt_s = (key_code_s == K_LT);
      key_rt_s = (key_code_s == K_RT);
    end else begin
      key_en_s = 1'b0;
    end
  end

  // Tick enters the carry chain only in RUN; ticks in EDIT are dropped
  assign carry_s[0] = tick & (mode_r == MODE_RUN);

  // Mode FSM, cursor and the rollover pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r     <= MODE_RUN;
      cursor_r   <= CUR_ZERO;
      rollover_r <= 1'b0;
    end else begin
      // Every field wrapped on this tick when the carry leaves the top field
      rollover_r <= carry_s[NCH];
      case (mode_r)
        MODE_RUN: begin
          if (key_en_s) begin
            mode_r <= MODE_EDIT;
          end else begin
            mode_r <= MODE_RUN;
          end
        end
        MODE_EDIT: begin
          if (key_en_s) begin
            mode_r <= MODE_RUN;
          end else if (key_lt_s) begin
            cursor_r <= (cursor_r == CUR_LAST) ? CUR_ZERO : cursor_r + CW'(1);
          end else if (key_rt_s) begin
            cursor_r <= (cursor_r == CUR_ZERO) ? CUR_LAST : cursor_r - CW'(1);
          end else begin
            mode_r <= MODE_EDIT;
          end
        end
        default: begin
          mode_r <= MODE_RUN;
        end
      endcase
    end
  end

  // One register per field with its own wrap limit and carry hand-off
  for (genvar i = 0; i < NCH; i++) begin : g_field
    localparam logic [W-1:0]  MAX_I = MAXV[i*W +: W];
    localparam logic [CW-1:0] IDX   = CW'(i);

    logic [W-1:0] field_r;
    logic         sel_s;

    assign wrap_s[i]    = (field_r == MAX_I);
    assign carry_s[i+1] = carry_s[i] & wrap_s[i];
    assign sel_s        = in_edit_s & (cursor_r == IDX);
    assign cuenta[i*W +: W] = field_r;

    // Count on incoming carry in RUN, step without carry when selected in EDIT
    always_ff @(posedge clk) begin
      if (rst) begin
        field_r <= {W{1'b0}};
      end else if (carry_s[i]) begin
        field_r <= wrap_s[i] ? {W{1'b0}} : field_r + W'(1);
      end else if (sel_s && key_up_s) begin
        field_r <= wrap_s[i] ? {W{1'b0}} : field_r + W'(1);
      end else if (sel_s && key_dn_s) begin
        field_r <= (field_r == {W{1'b0}}) ? MAX_I : field_r - W'(1);
      end else begin
        field_r <= field_r;
      end
    end
  end

  assign cursor   = cursor_r;
  assign editing  = (mode_r == MODE_EDIT);
  assign rollover = rollover_r;

endmodule

// File: tb/tb_time_field_adjuster.sv
// Directed self-checking bench for time_field_adjuster.
module tb_time_field_adjuster;

  logic        clk;
  logic        rst;
  logic [7:0]  scan_code;
  logic        got_data;
  logic        tick;
  logic [17:0] cuenta;
  logic [1:0]  cursor;
  logic        editing;
  logic        rollover;

  int total;
  int bad;

  time_field_adjuster dut (
    .clk       (clk),
    .rst       (rst),
    .scan_code (scan_code),
    .got_data  (got_data),
    .tick      (tick),
    .cuenta    (cuenta),
    .cursor    (cursor),
    .editing   (editing),
    .rollover  (rollover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] hms(input int h, input int m, input int s);
    return {h[5:0], m[5:0], s[5:0]};
  endfunction

  // Byte strobe; returns after the edge that applies the key
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    scan_code = b;
    got_data  = 1'b1;
    @(negedge clk);
    got_data  = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Key strobe with the tick landing on the same cycle as key_valid
  task automatic key_with_tick(input logic [7:0] b);
    @(negedge clk);
    scan_code = b;
    got_data  = 1'b1;
    @(negedge clk);
    got_data  = 1'b0;
    tick      = 1'b1;
    @(negedge clk);
    tick      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++;
    if (cuenta !== 18'd0 || cursor !== 2'd0 || editing !== 1'b0 || rollover !== 1'b0) begin
      bad++;
      $display("FAIL reset_init got cuenta=%h cur=%0d ed=%b ro=%b want all 0", cuenta, cursor, editing, rollover);
    end
    send_byte(8'h5A);
    repeat (5) send_byte(8'h75);
    send_byte(8'h6B);
    repeat (5) send_byte(8'h75);
    send_byte(8'h6B);
    repeat (5) send_byte(8'h75);
    total++;
    if (cuenta !== hms(5, 5, 5) || cursor !== 2'd2 || editing !== 1'b1) begin
      bad++;
      $display("FAIL reset_preload got cuenta=%h cur=%0d ed=%b want %h/2/1", cuenta, cursor, editing, hms(5, 5, 5));
    end
    pulse_reset();
    total++;
    if (cuenta !== 18'd0 || cursor !== 2'd0 || editing !== 1'b0 || rollover !== 1'b0) begin
      bad++;
      $display("FAIL reset_clear got cuenta=%h cur=%0d ed=%b ro=%b want all 0", cuenta, cursor, editing, rollover);
    end
  endtask

  task automatic test_run_rollover();
    send_byte(8'h5A);
    send_byte(8'h72);
    send_byte(8'h6B);
    send_byte(8'h72);
    send_byte(8'h6B);
    send_byte(8'h72);
    send_byte(8'h5A);
    total++;
    if (cuenta !== hms(23, 59, 59) || editing !== 1'b0 || cursor !== 2'd2) begin
      bad++;
      $display("FAIL run_setup got cuenta=%h ed=%b cur=%0d want %h/0/2", cuenta, editing, cursor, hms(23, 59, 59));
    end
    send_tick();
    total++;
    if (cuenta !== 18'd0 || rollover !== 1'b1) begin
      bad++;
      $display("FAIL run_wrap got cuenta=%h ro=%b want 0/1", cuenta, rollover);
    end
    @(negedge clk);
    total++;
    if (rollover !== 1'b0) begin
      bad++;
      $display("FAIL run_ro_pulse got ro=%b want 0", rollover);
    end
    send_tick();
    total++;
    if (cuenta !== hms(0, 0, 1) || rollover !== 1'b0) begin
      bad++;
      $display("FAIL run_next got cuenta=%h ro=%b want %h/0", cuenta, rollover, hms(0, 0, 1));
    end
  endtask

  task automatic test_mode_wrap();
    pulse_reset();
    send_byte(8'h5A);
    send_byte(8'hF0);
    send_byte(8'h5A);
    total++;
    if (editing !== 1'b1) begin
      bad++;
      $display("FAIL mode_release got ed=%b want 1", editing);
    end
    send_byte(8'h74);
    total++;
    if (cursor !== 2'd2) begin
      bad++;
      $display("FAIL cursor_rt_wrap got cur=%0d want 2", cursor);
    end
    send_byte(8'h72);
    total++;
    if (cuenta !== hms(23, 0, 0)) begin
      bad++;
      $display("FAIL hours_dn_wrap got cuenta=%h want %h", cuenta, hms(23, 0, 0));
    end
    send_byte(8'h75);
    total++;
    if (cuenta !== hms(0, 0, 0)) begin
      bad++;
      $display("FAIL hours_up_wrap got cuenta=%h want %h", cuenta, hms(0, 0, 0));
    end
    send_byte(8'h6B);
    total++;
    if (cursor !== 2'd0) begin
      bad++;
      $display("FAIL cursor_lt_wrap got cur=%0d want 0", cursor);
    end
  endtask

  task automatic test_edit_no_borrow();
    send_byte(8'h72);
    total++;
    if (cuenta !== hms(0, 0, 59)) begin
      bad++;
      $display("FAIL edit_no_borrow got cuenta=%h want %h", cuenta, hms(0, 0, 59));
    end
    send_tick();
    send_tick();
    total++;
    if (cuenta !== hms(0, 0, 59) || rollover !== 1'b0) begin
      bad++;
      $display("FAIL edit_tick_drop got cuenta=%h ro=%b want %h/0", cuenta, rollover, hms(0, 0, 59));
    end
    key_with_tick(8'h5A);
    total++;
    if (cuenta !== hms(0, 0, 59) || editing !== 1'b0) begin
      bad++;
      $display("FAIL edit_en_tick got cuenta=%h ed=%b want %h/0", cuenta, editing, hms(0, 0, 59));
    end
    key_with_tick(8'h5A);
    total++;
    if (cuenta !== hms(0, 1, 0) || editing !== 1'b1) begin
      bad++;
      $display("FAIL run_en_tick got cuenta=%h ed=%b want %h/1", cuenta, editing, hms(0, 1, 0));
    end
  endtask

  task automatic test_prefix_latency();
    send_byte(8'hE0);
    @(negedge clk);
    scan_code = 8'h75;
    got_data  = 1'b1;
    @(negedge clk);
    got_data  = 1'b0;
    total++;
    if (cuenta !== hms(0, 1, 0)) begin
      bad++;
      $display("FAIL latency_early got cuenta=%h want %h", cuenta, hms(0, 1, 0));
    end
    @(negedge clk);
    total++;
    if (cuenta !== hms(0, 1, 1)) begin
      bad++;
      $display("FAIL latency_applied got cuenta=%h want %h", cuenta, hms(0, 1, 1));
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    total++;
    if (cuenta !== hms(0, 1, 1)) begin
      bad++;
      $display("FAIL ext_release got cuenta=%h want %h", cuenta, hms(0, 1, 1));
    end
    send_byte(8'hF0);
    send_byte(8'hE0);
    send_byte(8'h75);
    total++;
    if (cuenta !== hms(0, 1, 1)) begin
      bad++;
      $display("FAIL brk_keeps_e0 got cuenta=%h want %h", cuenta, hms(0, 1, 1));
    end
    send_byte(8'h75);
    total++;
    if (cuenta !== hms(0, 1, 2)) begin
      bad++;
      $display("FAIL brk_cleared got cuenta=%h want %h", cuenta, hms(0, 1, 2));
    end
  endtask

  task automatic test_reset_aborts_break();
    send_byte(8'hF0);
    pulse_reset();
    total++;
    if (editing !== 1'b0 || cuenta !== 18'd0) begin
      bad++;
      $display("FAIL brk_reset got ed=%b cuenta=%h want 0/0", editing, cuenta);
    end
    send_byte(8'h5A);
    total++;
    if (editing !== 1'b1) begin
      bad++;
      $display("FAIL brk_abort got ed=%b want 1", editing);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    scan_code = 8'h00;
    got_data  = 1'b0;
    tick      = 1'b0;
    test_reset();
    test_run_rollover();
    test_mode_wrap();
    test_edit_no_borrow();
    test_prefix_latency();
    test_reset_aborts_break();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
